// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bundle for conv_window_gen.
// The slave modport is the window generator; master is whoever feeds it and consumes windows.
interface conv_window_gen_if #(
  parameter int lenOfInput = 8,
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  logic                         in_valid;
  logic                         in_sof;
  logic signed [lenOfInput-1:0] in_pixel;
  logic                         in_ready;

  logic signed [lenOfInput-1:0] data00, data01, data02, data03;
  logic signed [lenOfInput-1:0] data10, data11, data12, data13;
  logic signed [lenOfInput-1:0] data20, data21, data22, data23;
  logic signed [lenOfInput-1:0] data30, data31, data32, data33;
  logic                         win_valid;
  logic                         out_ready;
  logic [RW-1:0]                win_row;
  logic [CW-1:0]                win_col;
  logic                         frame_done;

  modport master (
    output in_valid, in_sof, in_pixel, out_ready,
    input  in_ready, win_valid, win_row, win_col, frame_done,
    input  data00, data01, data02, data03, data10, data11, data12, data13,
    input  data20, data21, data22, data23, data30, data31, data32, data33
  );

  modport slave (
    input  in_valid, in_sof, in_pixel, out_ready,
    output in_ready, win_valid, win_row, win_col, frame_done,
    output data00, data01, data02, data03, data10, data11, data12, data13,
    output data20, data21, data22, data23, data30, data31, data32, data33
  );
endinterface

// File: rtl/conv_window_gen.sv
// 4x4 sliding-window generator: three line buffers feed a column shift register,
// and each accepted pixel at row>=3, col>=3 registers one full window.
module conv_window_gen #(
  parameter int lenOfInput = 8,
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32
) (
  input logic             clk,
  input logic             rst,
  conv_window_gen_if.slave bus
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  typedef logic signed [lenOfInput-1:0] pix_t;

  logic [RW-1:0] row_reg, cur_row, row_next;
  logic [CW-1:0] col_reg, cur_col, col_next;
  logic          accept;
  logic          emit;
  logic          last_pix;

  logic          win_valid_reg;
  logic          frame_done_reg;
  logic [RW-1:0] win_row_reg;
  logic [CW-1:0] win_col_reg;

  // tap[k] is the pixel k rows above the incoming one, same column
  pix_t tap [4];
  pix_t shift_reg [4][3];

  assign bus.in_ready = !win_valid_reg || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign tap[0]       = bus.in_pixel;

  always_comb begin
    cur_row  = bus.in_sof ? '0 : row_reg;
    cur_col  = bus.in_sof ? '0 : col_reg;
    row_next = cur_row;
    col_next = cur_col + CW'(1);
    if (cur_col == CW'(IMG_W - 1)) begin
      col_next = '0;
      row_next = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + RW'(1);
    end
  end

  assign emit     = accept && (cur_row >= RW'(3)) && (cur_col >= CW'(3));
  assign last_pix = (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));

  // Each buffer is read and rewritten at the same column, cascading rows downward
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lb
      pix_t mem [IMG_W];
      always_ff @(posedge clk) begin
        if (accept) begin
          mem[cur_col] <= tap[gi];
        end
      end
      assign tap[gi+1] = mem[cur_col];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < 4; r++) begin
        shift_reg[r][0] <= shift_reg[r][1];
        shift_reg[r][1] <= shift_reg[r][2];
        shift_reg[r][2] <= tap[3-r];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_reg        <= '0;
      col_reg        <= '0;
      win_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      win_row_reg    <= '0;
      win_col_reg    <= '0;
    end else begin
      if (accept) begin
        row_reg <= row_next;
        col_reg <= col_next;
      end
      if (emit) begin
        win_valid_reg  <= 1'b1;
        frame_done_reg <= last_pix;
        win_row_reg    <= cur_row - RW'(3);
        win_col_reg    <= cur_col - CW'(3);
      end else if (bus.out_ready) begin
        win_valid_reg  <= 1'b0;
        frame_done_reg <= 1'b0;
      end
    end
  end

  // Window element (R,C): columns 0..2 come from the shift register, column 3 is live
  generate
    for (gi = 0; gi < 16; gi++) begin : g_win
      localparam int R = gi / 4;
      localparam int C = gi % 4;
      pix_t q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q <= '0;
        end else if (emit) begin
          if (C == 3) q <= tap[3-R];
          else        q <= shift_reg[R][C];
        end
      end
    end
  endgenerate

  assign bus.win_valid  = win_valid_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.win_row    = win_row_reg;
  assign bus.win_col    = win_col_reg;

  assign bus.data00 = g_win[0].q;
  assign bus.data01 = g_win[1].q;
  assign bus.data02 = g_win[2].q;
  assign bus.data03 = g_win[3].q;
  assign bus.data10 = g_win[4].q;
  assign bus.data11 = g_win[5].q;
  assign bus.data12 = g_win[6].q;
  assign bus.data13 = g_win[7].q;
  assign bus.data20 = g_win[8].q;
  assign bus.data21 = g_win[9].q;
  assign bus.data22 = g_win[10].q;
  assign bus.data23 = g_win[11].q;
  assign bus.data30 = g_win[12].q;
  assign bus.data31 = g_win[13].q;
  assign bus.data32 = g_win[14].q;
  assign bus.data33 = g_win[15].q;
endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen on an 8x6 image: an image-array model predicts every window,
// checked at consumption, plus directed backpressure, mid-frame SOF and reset scenarios.
module tb_conv_window_gen;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int L  = 8;
  localparam int FRAME_PIX = W * H;
  localparam int WIN_PER_FRAME = (W - 3) * (H - 3);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv_window_gen_if #(.lenOfInput(L), .IMG_W(W), .IMG_H(H)) bus ();

  conv_window_gen #(.lenOfInput(L), .IMG_W(W), .IMG_H(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [127:0] data;
    int           row;
    int           col;
    bit           fd;
  } win_t;

  win_t         exp_q[$];
  win_t         cur_exp;
  logic [L-1:0] img [H][W];
  int           mr = 0;
  int           mc = 0;
  int           win_count = 0;
  int           fd_count  = 0;
  int           or_mode   = 0;
  bit           prev_stall = 0;
  logic [127:0] stall_snap;

  function automatic logic [127:0] bus_window();
    return {bus.data00, bus.data01, bus.data02, bus.data03,
            bus.data10, bus.data11, bus.data12, bus.data13,
            bus.data20, bus.data21, bus.data22, bus.data23,
            bus.data30, bus.data31, bus.data32, bus.data33};
  endfunction

  // Model: store every accepted pixel at its image coordinate; a pixel at (r>=3,c>=3)
  // completes the 4x4 block whose bottom-right corner it is.
  task automatic model_accept(input logic [L-1:0] pix, input bit sof);
    win_t w;
    if (sof) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = pix;
    if (mr >= 3 && mc >= 3) begin
      w.data = '0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          w.data = (w.data << L) | 128'(img[mr-3+r][mc-3+c]);
      w.row = mr - 3;
      w.col = mc - 3;
      w.fd  = (mr == H - 1) && (mc == W - 1);
      exp_q.push_back(w);
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr = (mr + 1) % H;
    end
  endtask

  always @(posedge rst) begin
    exp_q.delete();
    mr = 0;
    mc = 0;
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (bus.win_valid && !bus.out_ready) begin
        check("stall_in_ready", 128'(bus.in_ready), 128'(0));
        if (prev_stall) check("stall_hold", bus_window(), stall_snap);
        stall_snap = bus_window();
        prev_stall = 1;
      end else begin
        prev_stall = 0;
      end
      if (bus.win_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_window", 128'(1), 128'(0));
        end else begin
          cur_exp = exp_q.pop_front();
          check("win_data", bus_window(), cur_exp.data);
          check("win_row", 128'(bus.win_row), 128'(cur_exp.row));
          check("win_col", 128'(bus.win_col), 128'(cur_exp.col));
          check("frame_done", 128'(bus.frame_done), 128'(cur_exp.fd));
        end
        win_count++;
        if (bus.frame_done) fd_count++;
      end
      if (bus.in_valid && bus.in_ready) model_accept(bus.in_pixel, bus.in_sof);
    end
  end

  always @(posedge clk) begin
    #1;
    if (or_mode == 1) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send_pixel(input logic [L-1:0] v, input bit sof);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_pixel = v;
    bus.in_sof   = sof;
    @(negedge clk);
    while (!bus.in_ready && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 1000) check("accept_timeout", 128'(1), 128'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Ramp pixels equal their raster index (8*r+c for this width)
  task automatic send_pixels(input int npix, input bit rnd, input bit gaps, input bit first_sof);
    for (int i = 0; i < npix; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle(1);
      send_pixel(rnd ? L'($urandom_range(0, 255)) : L'(i), (i == 0) && first_sof);
    end
    idle(1);
  endtask

  task automatic frame_counts(input string tag);
    idle(20);
    check({tag, "_windows"}, 128'(win_count), 128'(WIN_PER_FRAME));
    check({tag, "_fd_count"}, 128'(fd_count), 128'(1));
    check({tag, "_queue"}, 128'(exp_q.size()), 128'(0));
    win_count = 0;
    fd_count  = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_win_valid"}, 128'(bus.win_valid), 128'(0));
    check({tag, "_frame_done"}, 128'(bus.frame_done), 128'(0));
    check({tag, "_data"}, bus_window(), 128'(0));
    check({tag, "_win_row"}, 128'(bus.win_row), 128'(0));
    check({tag, "_win_col"}, 128'(bus.win_col), 128'(0));
  endtask

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_pixel  = '0;
    bus.out_ready = 1'b1;

    #1 rst = 1'b1;
    #1 check_zero_outputs("reset");
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    win_count = 0;
    fd_count  = 0;

    // Full ramp frame, always ready
    send_pixels(FRAME_PIX, 0, 0, 1);
    frame_counts("ramp");

    // Backpressure: stall 5 cycles from the first window
    fork
      send_pixels(FRAME_PIX, 0, 0, 1);
      begin
        n = 0;
        @(negedge clk);
        while (!(bus.in_valid && bus.in_ready && bus.in_pixel == L'(27)) && n < 500) begin
          n++;
          @(negedge clk);
        end
        if (n >= 500) check("bp_timeout", 128'(1), 128'(0));
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        check("bp_data33", 128'(bus.data33), 128'(27));
        check("bp_in_ready", 128'(bus.in_ready), 128'(0));
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    frame_counts("backpressure");

    // SOF at old position (4,2), then a fresh frame
    send_pixels(34, 0, 0, 1);
    idle(5);
    win_count = 0;
    fd_count  = 0;
    send_pixels(FRAME_PIX, 0, 0, 1);
    frame_counts("sof_mid");

    // Reset while a window is held; next pixel after reset is (0,0) without SOF
    bus.out_ready = 1'b0;
    for (int i = 0; i < 28; i++) send_pixel(L'(i), i == 0);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    check("pre_rst_valid", 128'(bus.win_valid), 128'(1));
    #1 rst = 1'b1;
    #1 check_zero_outputs("mid_rst");
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    win_count = 0;
    fd_count  = 0;
    send_pixels(FRAME_PIX, 0, 0, 0);
    frame_counts("post_rst");

    // Randomized pixels, input gaps and output backpressure
    or_mode = 1;
    for (int f = 0; f < 4; f++) begin
      if (f == 2) begin
        send_pixels($urandom_range(5, FRAME_PIX - 2), 1, 1, 1);
        idle(20);
        win_count = 0;
        fd_count  = 0;
      end
      send_pixels(FRAME_PIX, 1, 1, 1);
      frame_counts("random");
    end
    or_mode = 0;
    bus.out_ready = 1'b1;
    idle(5);
    check("final_queue", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
